// File: rtl/eth_debug_pkg.sv
// Shared definitions for the debug-path character formatting blocks.
package eth_debug_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    SEP  = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } framer_state_t;

endpackage : eth_debug_pkg

// File: rtl/hex_line_framer_idle_timer.sv
// Idle gap counter: counts enabled cycles, flags the last cycle of the gap.
module idle_timer #(
  parameter int N = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] idle_cnt_q;
  logic [W-1:0] idle_cnt_d;

  // Next count: clear wins over counting, otherwise hold.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (clr) begin
      idle_cnt_d = '0;
    end else if (en) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign expire = (idle_cnt_q == LAST);

endmodule : idle_timer

// File: rtl/hex_line_framer.sv
// Formats the ASCII hex-character debug stream into terminal lines:
// separator after each character pair, CR LF after a full line or an idle gap.
module hex_line_framer
  import eth_debug_pkg::*;
#(
  parameter int         BYTES_PER_LINE = 8,
  parameter int         IDLE_CYCLES    = 1_000_000,
  parameter logic [7:0] SEP_CHAR       = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_wr,
  output logic [7:0] out_data,
  input  logic       out_full
);

  localparam int PW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(BYTES_PER_LINE - 1);

  framer_state_t state_q, state_d;
  logic          char_odd_q, char_odd_d;
  logic [PW-1:0] pair_cnt_q, pair_cnt_d;

  logic       in_ready_c;
  logic       out_wr_c;
  logic [7:0] out_data_c;
  logic       idle_en;
  logic       idle_clr;
  logic       idle_expire;
  logic       flush;

  idle_timer #(
    .N(IDLE_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .en    (idle_en),
    .clr   (idle_clr),
    .expire(idle_expire)
  );

  // Next-state, pair/odd bookkeeping and the zero-latency output mux.
  always_comb begin
    state_d    = state_q;
    char_odd_d = char_odd_q;
    pair_cnt_d = pair_cnt_q;
    in_ready_c = 1'b0;
    out_wr_c   = 1'b0;
    out_data_c = 8'h00;
    idle_en    = 1'b0;
    flush      = 1'b0;

    case (state_q)
      PASS: begin
        in_ready_c = ~out_full;
        if (in_valid && !out_full) begin
          out_wr_c   = 1'b1;
          out_data_c = in_data;
          char_odd_d = ~char_odd_q;
          if (char_odd_q) begin
            if (pair_cnt_q == LAST_PAIR) begin
              state_d    = CR;
              pair_cnt_d = '0;
            end else begin
              state_d    = SEP;
              pair_cnt_d = pair_cnt_q + 1'b1;
            end
          end
        end else begin
          // A transfer always beats the timeout; only a quiet, non-empty line ages.
          idle_en = (pair_cnt_q != '0) || char_odd_q;
          if (idle_en && idle_expire) begin
            flush      = 1'b1;
            state_d    = CR;
            pair_cnt_d = '0;
            char_odd_d = 1'b0;
          end
        end
      end
      SEP: begin
        out_wr_c   = ~out_full;
        out_data_c = SEP_CHAR;
        if (!out_full) state_d = PASS;
      end
      CR: begin
        out_wr_c   = ~out_full;
        out_data_c = ASCII_CR;
        if (!out_full) state_d = LF;
      end
      LF: begin
        out_wr_c   = ~out_full;
        out_data_c = ASCII_LF;
        if (!out_full) state_d = PASS;
      end
      default: begin
        state_d = PASS;
      end
    endcase

    idle_clr = ~idle_en | flush;
  end

  // State and line-position registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PASS;
      char_odd_q <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      char_odd_q <= char_odd_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  // Outputs are forced quiet for as long as reset is held low.
  assign in_ready = reset & in_ready_c;
  assign out_wr   = reset & out_wr_c;
  assign out_data = reset ? out_data_c : 8'h00;

endmodule : hex_line_framer
